// File: rtl/sliu_vga_pkg.sv
// rtl/sliu_vga_pkg.sv - 640x480@60 VGA timing constants and TinyVGA PMOD pin layout
package sliu_vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    // TinyVGA PMOD order: low colour bits share the nibble with hsync, high bits with vsync
    typedef struct packed {
        logic hsync;
        logic b0;
        logic g0;
        logic r0;
        logic vsync;
        logic b1;
        logic g1;
        logic r1;
    } uo_pins_t;

    localparam uo_pins_t UO_RESET = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};

    function automatic uo_pins_t pack_uo(input logic hs, input logic vs, input rgb_t c);
        uo_pins_t p;
        p.hsync = hs;
        p.b0    = c.b[0];
        p.g0    = c.g[0];
        p.r0    = c.r[0];
        p.vsync = vs;
        p.b1    = c.b[1];
        p.g1    = c.g[1];
        p.r1    = c.r[1];
        return p;
    endfunction

endpackage

// File: rtl/sliu_vga_bouncer_if.sv
// rtl/sliu_vga_bouncer_if.sv - TinyTapeout tile pin bundle for the VGA bouncer
interface sliu_vga_bouncer_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/sliu_vga_timing.sv
// rtl/sliu_vga_timing.sv - VGA pixel/line counters, active-low syncs and per-frame tick
module sliu_vga_timing
    import sliu_vga_pkg::*;
#(
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FP_P     = H_FP,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_TOTAL_P  = H_TOTAL,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_TOTAL_P  = V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       active_o,
    output logic       frame_tick_o
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL_P - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL_P - 1);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE_P + H_FP_P);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE_P + V_FP_P);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o       = hcnt_q;
    assign vcnt_o       = vcnt_q;
    assign hsync_o      = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    assign vsync_o      = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
    assign active_o     = (hcnt_q < 10'(H_ACTIVE_P)) && (vcnt_q < 10'(V_ACTIVE_P));
    assign frame_tick_o = (hcnt_q == '0) && (vcnt_q == 10'(V_ACTIVE_P));

endmodule

// File: rtl/sliu_vga_bouncer.sv
// rtl/sliu_vga_bouncer.sv - bouncing-square VGA tile: motion, pixel mux, registered PMOD output
// Build option GRID_OVERLAY_EN adds a 32-pixel grid over the background.
module sliu_vga_bouncer
    import sliu_vga_pkg::*;
#(
    parameter int SQ_SIZE    = 32,
    parameter int INIT_X     = 304,
    parameter int INIT_Y     = 224,
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FP_P     = H_FP,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_TOTAL_P  = H_TOTAL,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_TOTAL_P  = V_TOTAL
) (
    input  logic               clk,
    input  logic               rst,
    sliu_vga_bouncer_if.slave  tt_io
);

    localparam logic [9:0] X_LIMIT = 10'(H_ACTIVE_P - SQ_SIZE);
    localparam logic [8:0] Y_LIMIT = 9'(V_ACTIVE_P - SQ_SIZE);

    logic [9:0] hcnt, vcnt;
    logic       hsync, vsync, active, frame_tick;

    sliu_vga_timing #(
        .H_ACTIVE_P (H_ACTIVE_P),
        .H_FP_P     (H_FP_P),
        .H_SYNC_P   (H_SYNC_P),
        .H_TOTAL_P  (H_TOTAL_P),
        .V_ACTIVE_P (V_ACTIVE_P),
        .V_FP_P     (V_FP_P),
        .V_SYNC_P   (V_SYNC_P),
        .V_TOTAL_P  (V_TOTAL_P)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .hcnt_o       (hcnt),
        .vcnt_o       (vcnt),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .active_o     (active),
        .frame_tick_o (frame_tick)
    );

    logic [9:0] x_pos_q, x_pos_d;
    logic [8:0] y_pos_q, y_pos_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic [2:0] step;
    uo_pins_t   uo_q, uo_d;
    rgb_t       pix;
    logic       in_sq;

    assign step = 3'(tt_io.ui_in[2:1]) + 3'd1;

    // dx/dy high means moving towards larger coordinates
    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        if (frame_tick && !tt_io.ui_in[0]) begin
            if (dx_q) begin
                if (x_pos_q + 10'(step) >= X_LIMIT) begin
                    x_pos_d = X_LIMIT;
                    dx_d    = 1'b0;
                end else begin
                    x_pos_d = x_pos_q + 10'(step);
                end
            end else if (x_pos_q < 10'(step)) begin
                x_pos_d = '0;
                dx_d    = 1'b1;
            end else begin
                x_pos_d = x_pos_q - 10'(step);
            end

            if (dy_q) begin
                if (y_pos_q + 9'(step) >= Y_LIMIT) begin
                    y_pos_d = Y_LIMIT;
                    dy_d    = 1'b0;
                end else begin
                    y_pos_d = y_pos_q + 9'(step);
                end
            end else if (y_pos_q < 9'(step)) begin
                y_pos_d = '0;
                dy_d    = 1'b1;
            end else begin
                y_pos_d = y_pos_q - 9'(step);
            end
        end
    end

    assign in_sq = ({1'b0, hcnt} >= {1'b0, x_pos_q})
                && ({1'b0, hcnt} <  ({1'b0, x_pos_q} + 11'(SQ_SIZE)))
                && ({1'b0, vcnt} >= {2'b0, y_pos_q})
                && ({1'b0, vcnt} <  ({2'b0, y_pos_q} + 11'(SQ_SIZE)));

    always_comb begin
        pix = '0;
        if (active) begin
            if (in_sq) begin
                pix.r = {2{tt_io.ui_in[3]}};
                pix.g = {2{tt_io.ui_in[4]}};
                pix.b = {2{tt_io.ui_in[5]}};
`ifdef GRID_OVERLAY_EN
            end else if ((hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0)) begin
                pix.r = 2'b01;
                pix.g = 2'b01;
                pix.b = 2'b01;
`endif
            end else begin
                pix.r = tt_io.ui_in[7:6];
                pix.g = tt_io.ui_in[7:6];
                pix.b = tt_io.ui_in[7:6];
            end
        end
    end

    assign uo_d = pack_uo(hsync, vsync, pix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_pos_q <= 10'(INIT_X);
            y_pos_q <= 9'(INIT_Y);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            uo_q    <= UO_RESET;
        end else begin
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            uo_q    <= uo_d;
        end
    end

    assign tt_io.uo_out  = uo_q;
    assign tt_io.uio_out = '0;
    assign tt_io.uio_oe  = '0;

    logic unused_pins;
    assign unused_pins = ^{tt_io.ena, tt_io.uio_in};

endmodule

// File: tb/tb_sliu_vga_bouncer.sv
// tb/tb_sliu_vga_bouncer.sv - scoreboard bench: full-size sync checks plus a shrunken-raster DUT for frame/motion
module tb_sliu_vga_bouncer;

    localparam int HA = 48, HF = 4, HS = 8, HT = 64;
    localparam int VA = 32, VF = 2, VS = 2, VT = 38;
    localparam int SQ = 8, IX = 20, IY = 12;
    localparam int FT = HT * VT;

    typedef struct packed { int at; int h; int v; logic [7:0] exp; } probe_t;
    typedef struct packed { int at; logic lvl; } edge_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;

    probe_t sb[$];
    edge_t  eq_full[$];
    edge_t  eq_small[$];

    sliu_vga_bouncer_if tt_full();
    sliu_vga_bouncer_if tt_small();

    sliu_vga_bouncer u_full (
        .clk   (clk),
        .rst   (rst),
        .tt_io (tt_full)
    );

    sliu_vga_bouncer #(
        .SQ_SIZE(SQ), .INIT_X(IX), .INIT_Y(IY),
        .H_ACTIVE_P(HA), .H_FP_P(HF), .H_SYNC_P(HS), .H_TOTAL_P(HT),
        .V_ACTIVE_P(VA), .V_FP_P(VF), .V_SYNC_P(VS), .V_TOTAL_P(VT)
    ) u_small (
        .clk   (clk),
        .rst   (rst),
        .tt_io (tt_small)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exceeded, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Cycle (posedges since reset release) at which uo_out shows pixel (h,v) of frame f
    function automatic int pix(input int f, input int h, input int v);
        return f * FT + v * HT + h + 1;
    endfunction

    function automatic logic [7:0] exp_uo(input int h, input int v, input int x, input int y,
                                          input logic [7:0] u);
        logic hs, vs;
        logic [1:0] r, g, b;
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        r = 2'b00; g = 2'b00; b = 2'b00;
        if (h < HA && v < VA) begin
            if (h >= x && h < x + SQ && v >= y && v < y + SQ) begin
                r = {2{u[3]}}; g = {2{u[4]}}; b = {2{u[5]}};
`ifdef GRID_OVERLAY_EN
            end else if (h % 32 == 0 || v % 32 == 0) begin
                r = 2'b01; g = 2'b01; b = 2'b01;
`endif
            end else begin
                r = u[7:6]; g = u[7:6]; b = u[7:6];
            end
        end
        return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    endfunction

    function automatic void step_axis(inout int p, inout bit dir, input int st, input int lim);
        if (dir) begin
            if (p + st >= lim) begin p = lim; dir = 1'b0; end
            else p = p + st;
        end else if (p < st) begin
            p = 0; dir = 1'b1;
        end else begin
            p = p - st;
        end
    endfunction

    task automatic set_ui(input logic [7:0] u);
        tt_full.ui_in  = u;
        tt_small.ui_in = u;
    endtask

    task automatic do_reset(input logic [7:0] u);
        @(negedge clk);
        rst = 1'b1;
        set_ui(u);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int target, output bit ok);
        int guard;
        guard = 0;
        if (cyc > target) begin
            ok = 1'b0;
            return;
        end
        while (cyc != target && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        ok = (cyc == target);
    endtask

    task automatic push_square(input int f, input int x, input int y, input logic [7:0] u);
        if (x > 0) sb.push_back('{pix(f, x - 1, y), x - 1, y, exp_uo(x - 1, y, x, y, u)});
        sb.push_back('{pix(f, x, y), x, y, exp_uo(x, y, x, y, u)});
        sb.push_back('{pix(f, x + SQ, y), x + SQ, y, exp_uo(x + SQ, y, x, y, u)});
        sb.push_back('{pix(f, x + SQ - 1, y + SQ - 1), x + SQ - 1, y + SQ - 1,
                       exp_uo(x + SQ - 1, y + SQ - 1, x, y, u)});
    endtask

    task automatic test_reset();
        edge_t e;
        logic  pf, ps;
        tt_full.ena = 1'b1;  tt_full.uio_in = 8'h00;
        tt_small.ena = 1'b1; tt_small.uio_in = 8'h00;
        set_ui(8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (tt_full.uo_out !== 8'h88) begin n_bad++; $display("FAIL reset_uo_full: got %h want 88", tt_full.uo_out); end
        n_cmp++; if (tt_full.uio_oe !== 8'h00) begin n_bad++; $display("FAIL reset_uio_oe_full: got %h want 00", tt_full.uio_oe); end
        n_cmp++; if (tt_full.uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out_full: got %h want 00", tt_full.uio_out); end
        n_cmp++; if (tt_small.uo_out !== 8'h88) begin n_bad++; $display("FAIL reset_uo_small: got %h want 88", tt_small.uo_out); end
        n_cmp++; if (tt_small.uio_oe !== 8'h00) begin n_bad++; $display("FAIL reset_uio_oe_small: got %h want 00", tt_small.uio_oe); end
        n_cmp++; if (tt_small.uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out_small: got %h want 00", tt_small.uio_out); end

        eq_full.push_back('{657, 1'b0});
        eq_full.push_back('{753, 1'b1});
        eq_full.push_back('{1457, 1'b0});
        eq_small.push_back('{HA + HF + 1, 1'b0});
        eq_small.push_back('{HA + HF + HS + 1, 1'b1});
        eq_small.push_back('{HT + HA + HF + 1, 1'b0});
        pf = 1'b1;
        ps = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 1460; i++) begin
            @(negedge clk);
            if (tt_full.uo_out[7] !== pf) begin
                pf = tt_full.uo_out[7];
                n_cmp++;
                if (eq_full.size() == 0) begin
                    n_bad++; $display("FAIL hsync_full_edge: unexpected edge to %b at cycle %0d", pf, cyc);
                end else begin
                    e = eq_full.pop_front();
                    if (cyc !== e.at || pf !== e.lvl) begin
                        n_bad++; $display("FAIL hsync_full_edge: got level %b at cycle %0d want level %b at cycle %0d", pf, cyc, e.lvl, e.at);
                    end
                end
            end
            if (cyc <= 120 && tt_small.uo_out[7] !== ps) begin
                ps = tt_small.uo_out[7];
                n_cmp++;
                if (eq_small.size() == 0) begin
                    n_bad++; $display("FAIL hsync_small_edge: unexpected edge to %b at cycle %0d", ps, cyc);
                end else begin
                    e = eq_small.pop_front();
                    if (cyc !== e.at || ps !== e.lvl) begin
                        n_bad++; $display("FAIL hsync_small_edge: got level %b at cycle %0d want level %b at cycle %0d", ps, cyc, e.lvl, e.at);
                    end
                end
            end
        end
        while (eq_full.size() > 0) begin
            e = eq_full.pop_front(); n_cmp++; n_bad++;
            $display("FAIL hsync_full_edge: missing edge, got none want level %b at cycle %0d", e.lvl, e.at);
        end
        while (eq_small.size() > 0) begin
            e = eq_small.pop_front(); n_cmp++; n_bad++;
            $display("FAIL hsync_small_edge: missing edge, got none want level %b at cycle %0d", e.lvl, e.at);
        end
    endtask

    task automatic test_frame_timing();
        edge_t e;
        logic  pv;
        do_reset(8'h00);
        eq_small.push_back('{(VA + VF) * HT + 1, 1'b0});
        eq_small.push_back('{(VA + VF + VS) * HT + 1, 1'b1});
        eq_small.push_back('{FT + (VA + VF) * HT + 1, 1'b0});
        pv = 1'b1;
        for (int i = 0; i < FT + (VA + VF) * HT + 12; i++) begin
            @(negedge clk);
            if (tt_small.uo_out[3] !== pv) begin
                pv = tt_small.uo_out[3];
                n_cmp++;
                if (eq_small.size() == 0) begin
                    n_bad++; $display("FAIL vsync_edge: unexpected edge to %b at cycle %0d", pv, cyc);
                end else begin
                    e = eq_small.pop_front();
                    if (cyc !== e.at || pv !== e.lvl) begin
                        n_bad++; $display("FAIL vsync_edge: got level %b at cycle %0d want level %b at cycle %0d", pv, cyc, e.lvl, e.at);
                    end
                end
            end
        end
        while (eq_small.size() > 0) begin
            e = eq_small.pop_front(); n_cmp++; n_bad++;
            $display("FAIL vsync_edge: missing edge, got none want level %b at cycle %0d", e.lvl, e.at);
        end
    endtask

    task automatic test_colours();
        probe_t p;
        bit     ok;
        do_reset(8'b11_001_000);
        sb.push_back('{pix(0, 0, 0), 0, 0, 8'hFF});
        sb.push_back('{pix(0, HA, 0), HA, 0, 8'h88});
        sb.push_back('{pix(0, IX - 1, IY), IX - 1, IY, 8'hFF});
        sb.push_back('{pix(0, IX, IY), IX, IY, 8'h99});
        sb.push_back('{pix(0, IX + SQ - 1, IY + SQ - 1), IX + SQ - 1, IY + SQ - 1, 8'h99});
        sb.push_back('{pix(0, IX + SQ, IY + SQ - 1), IX + SQ, IY + SQ - 1, 8'hFF});
        sb.push_back('{pix(0, 0, VA), 0, VA, 8'h88});
        sb.push_back('{pix(1, IX + 3, IY + 3), IX + 3, IY + 3, 8'h99});
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL colours px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL colours px(%0d,%0d): got %h want %h", p.h, p.v, tt_small.uo_out, p.exp);
            end
        end
        // Square became blue, background grey 1: visible from the very next pixel
        set_ui(8'b01_100_000);
        sb.push_back('{pix(1, IX + 4, IY + 3), IX + 4, IY + 3, 8'hCC});
        sb.push_back('{pix(1, IX + SQ + 1, IY + 3), IX + SQ + 1, IY + 3, 8'hF8});
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL colour_change px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL colour_change px(%0d,%0d): got %h want %h", p.h, p.v, tt_small.uo_out, p.exp);
            end
        end
    endtask

    task automatic test_motion();
        probe_t p;
        bit     ok;
        int     x, y;
        bit     dx, dy;
        x = IX; y = IY; dx = 1'b1; dy = 1'b1;
        do_reset(8'b01_001_110);
        for (int f = 0; f < 12; f++) begin
            push_square(f, x, y, 8'b01_001_110);
            step_axis(x, dx, 4, HA - SQ);
            step_axis(y, dy, 4, VA - SQ);
        end
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL motion px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL motion px(%0d,%0d) frame %0d: got %h want %h", p.h, p.v, p.at / FT, tt_small.uo_out, p.exp);
            end
        end
    endtask

    task automatic test_pause();
        probe_t p;
        bit     ok;
        do_reset(8'b01_001_011);
        for (int f = 0; f < 4; f++) push_square(f, IX, IY, 8'b01_001_011);
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL pause px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL pause px(%0d,%0d) frame %0d: got %h want %h", p.h, p.v, p.at / FT, tt_small.uo_out, p.exp);
            end
        end
        // Resume at speed 2 inside frame 3, then drop to speed 1 inside frame 4
        set_ui(8'b01_001_010);
        push_square(4, IX + 2, IY + 2, 8'b01_001_010);
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL resume px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL resume px(%0d,%0d): got %h want %h", p.h, p.v, tt_small.uo_out, p.exp);
            end
        end
        set_ui(8'b01_001_000);
        push_square(5, IX + 3, IY + 3, 8'b01_001_000);
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL speed_change px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL speed_change px(%0d,%0d): got %h want %h", p.h, p.v, tt_small.uo_out, p.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int first_fall;
        do_reset(8'b01_001_000);
        wait_cyc(1000, ok);
        rst = 1'b1;
        #1;
        n_cmp++; if (tt_small.uo_out !== 8'h88) begin n_bad++; $display("FAIL midreset_uo_small: got %h want 88", tt_small.uo_out); end
        n_cmp++; if (tt_full.uo_out !== 8'h88) begin n_bad++; $display("FAIL midreset_uo_full: got %h want 88", tt_full.uo_out); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        first_fall = -1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++;
                if (tt_small.uo_out !== exp_uo(0, 0, IX, IY, 8'b01_001_000)) begin
                    n_bad++; $display("FAIL midreset_px00: got %h want %h", tt_small.uo_out, exp_uo(0, 0, IX, IY, 8'b01_001_000));
                end
            end
            if (first_fall < 0 && tt_small.uo_out[7] === 1'b0) first_fall = cyc;
        end
        n_cmp++;
        if (first_fall != HA + HF + 1) begin
            n_bad++; $display("FAIL midreset_hsync: first fall at cycle %0d want %0d", first_fall, HA + HF + 1);
        end
    endtask

`ifdef GRID_OVERLAY_EN
    task automatic test_grid();
        probe_t p;
        bit     ok;
        do_reset(8'b00_001_000);
        sb.push_back('{pix(0, 32, 10), 32, 10, 8'hF8});
        sb.push_back('{pix(0, 33, 10), 33, 10, 8'h88});
        while (sb.size() > 0) begin
            p = sb.pop_front();
            wait_cyc(p.at, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL grid px(%0d,%0d): sample point missed at cycle %0d want cycle %0d", p.h, p.v, cyc, p.at);
            end else if (tt_small.uo_out !== p.exp) begin
                n_bad++; $display("FAIL grid px(%0d,%0d): got %h want %h", p.h, p.v, tt_small.uo_out, p.exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_timing();
        test_colours();
        test_motion();
        test_pause();
        test_reset_mid();
`ifdef GRID_OVERLAY_EN
        test_grid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sliu_vga_bouncer.md
Name: sliu_vga_bouncer

Overview:
- TinyTapeout user tile: 640x480@60 Hz VGA generator drawing a 32x32 square that bounces off the screen edges over a solid background.
- Drives a TinyVGA PMOD on uo_out (2 bits per colour). Speed, pause and colours come from ui_in.
- Bidirectional pins are unused.

Parameters:
- SQ_SIZE, 32, square edge length in pixels.
- INIT_X, 304, square left edge after reset.
- INIT_Y, 224, square top edge after reset.

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal (25 MHz acceptable).
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  tile selected; ignored by logic.
- ui_in  in  8  [0] pause, [2:1] speed-1 (1..4 px/frame), [5:3] square colour {B,G,R}, [7:6] background grey level.
- uio_in  in  8  unused.
- uo_out  out  8  {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all inputs).

Behaviour:
- Counters: hcnt 0..799 and vcnt 0..524.
  - hcnt wraps to 0 after 799; vcnt increments on that wrap and itself wraps after 524.
- Active video: hcnt<640 && vcnt<480.
- Sync pulses are active low:
  - hsync low for hcnt 656..751.
  - vsync low for vcnt 490..491.
- Pixel selection:
  - Inside the square (x_pos<=hcnt<x_pos+32, y_pos<=vcnt<y_pos+32): colour per channel = ui_in[5:3] bit ? 2'b11 : 2'b00.
  - Elsewhere in active video: every channel = ui_in[7:6].
  - Outside active video: RGB = 0.
- Output timing: uo_out is registered, so sync and RGB share one cycle of latency relative to the counters.
- Motion:
  - x_pos (10 bit) and y_pos (9 bit) update once per frame, in the cycle where hcnt==0 && vcnt==480.
  - step = ui_in[2:1]+1. No update when ui_in[0]=1.
- Bounce:
  - If dx=+ and x_pos+step >= 640-32: set x_pos=608 and dx=−.
  - If dx=− and x_pos < step: set x_pos=0 and dx=+.
  - Y uses the same rule with limit 448.
  - X and Y are evaluated independently, so a corner bounce reverses both axes in the same update.
- Reset (async assert, sync release): hcnt=vcnt=0; x_pos=INIT_X, y_pos=INIT_Y; dx=+, dy=+; uo_out=8'b1000_1000 (syncs inactive, black).
- Reset mid-frame restarts timing at (0,0) immediately.
- Speed or colour changes mid-frame:
  - Colour takes effect on the next pixel.
  - Speed takes effect at the next frame update.

Optional Feature:
- Macro GRID_OVERLAY_EN.
  - Defined: in active video, pixels with hcnt[4:0]==0 or vcnt[4:0]==0 that are outside the square output RGB=2'b01 on all channels.
  - Not defined: no grid; pure background.
- Sync timing is unaffected either way.

Decomposition:
- Package sliu_vga_pkg holds:
  - H_ACTIVE=640, H_FP=16, H_SYNC=96, H_TOTAL=800.
  - V_ACTIVE=480, V_FP=10, V_SYNC=2, V_TOTAL=525.
  - The colour/pin-order typedef for uo_out.
- Sub-module sliu_vga_timing contains:
  - Counters, hsync/vsync/active signals.
  - A one-cycle frame_tick pulse at (0,480).
- Top level holds the square motion logic and the pixel mux.

Test Plan:
- Reset: hold rst=1 -> uo_out=8'h88, uio_oe=0, uio_out=0. Release -> first hsync falling edge at cycle 657 after release (656 plus 1 register cycle); line period 800 cycles.
- Frame timing -> vsync low for exactly 1600 cycles, starting at line 490; frame period 420000 cycles.
- ui_in=8'b11_001_000 (background 3, red square, speed 1) -> pixel (0,0) reads R=G=B=2'b11. Pixel (304,224) in frame 0 reads R=2'b11, G=B=0.
- Speed 4 (ui_in[2:1]=3), no pause:
  - Square moves +4 in x and y per frame.
  - After 76 frames x_pos reaches 608 and dx flips; the next frame x_pos=604.
- Pause (ui_in[0]=1) for 3 frames -> square position unchanged; it resumes when ui_in[0] is cleared.
- With GRID_OVERLAY_EN and background 0 -> pixel (32,100) reads RGB 01/01/01; pixel (33,100) reads 0.
